// File: rtl/gpr_write_ctrl_pkg.sv
// Shared widths, defaults and the buffered long-latency result type for the GPR write-side controller.
package gpr_write_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_bus_t;
    typedef logic [REG_DATA_W-1:0] reg_bus_t;

    localparam reg_addr_bus_t GPR_ZERO_ADDR = 5'd0;

    localparam int unsigned LU_FIFO_DEPTH_DEF = 2;
    localparam int unsigned STARVE_MAX_DEF    = 4;

    typedef struct packed {
        reg_addr_bus_t addr;
        reg_bus_t      data;
    } lu_entry_t;

    function automatic logic is_gpr_zero(input reg_addr_bus_t addr);
        return addr == GPR_ZERO_ADDR;
    endfunction

endpackage

// File: rtl/gpr_write_ctrl_wb_result_fifo.sv
// Synchronous FIFO buffering long-latency results ({addr, data}) until they win the GPR write port.
module wb_result_fifo
    import gpr_write_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = LU_FIFO_DEPTH_DEF
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push_i,
    input  lu_entry_t wdata_i,
    input  logic      pop_i,
    output lu_entry_t rdata_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    lu_entry_t        mem_q [DEPTH];
    lu_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_s, pop_s;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == {CNT_W{1'b0}});
    assign rdata_o = mem_q[rd_ptr_q];
    assign push_s  = push_i && !full_o;
    assign pop_s   = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/gpr_write_ctrl.sv
// GPR write-port owner: merges pipeline writeback with buffered long-latency results and tracks pending registers.
// Optional starvation hold of the pipeline is built when GPR_WB_STARVE_EN is defined.
module gpr_write_ctrl
    import gpr_write_ctrl_pkg::*;
#(
    parameter int unsigned LU_FIFO_DEPTH = LU_FIFO_DEPTH_DEF,
    parameter int unsigned STARVE_MAX    = STARVE_MAX_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pipe_we_i,
    input  reg_addr_bus_t pipe_addr_i,
    input  reg_bus_t      pipe_data_i,
    input  logic          lu_issue_i,
    input  reg_addr_bus_t lu_issue_addr_i,
    input  logic          lu_valid_i,
    input  reg_addr_bus_t lu_addr_i,
    input  reg_bus_t      lu_data_i,
    output logic          lu_ready_o,
    input  reg_addr_bus_t chk1_addr_i,
    input  reg_addr_bus_t chk2_addr_i,
    input  reg_addr_bus_t chkd_addr_i,
    output logic          hazard_o,
    output logic          pipe_hold_o,
    output logic          rd_write_o,
    output reg_addr_bus_t rd_addr_o,
    output reg_bus_t      write_data_o
);

    logic          full_s, empty_s, push_s, pop_s, pipe_win_s, pipe_hold_s;
    lu_entry_t     head_s;
    logic [31:0]   busy_q, busy_d;
    logic          rd_write_q, rd_write_d;
    reg_addr_bus_t rd_addr_q, rd_addr_d;
    reg_bus_t      write_data_q, write_data_d;

    assign lu_ready_o = !full_s;
    assign push_s     = lu_valid_i && !full_s;

    wb_result_fifo #(
        .DEPTH (LU_FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .wdata_i ({lu_addr_i, lu_data_i}),
        .pop_i   (pop_s),
        .rdata_o (head_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    always_comb begin
        pipe_win_s   = pipe_we_i && !is_gpr_zero(pipe_addr_i) && !pipe_hold_s;
        pop_s        = !pipe_win_s && !empty_s;
        rd_write_d   = 1'b0;
        rd_addr_d    = GPR_ZERO_ADDR;
        write_data_d = 32'd0;
        if (pipe_win_s) begin
            rd_write_d   = 1'b1;
            rd_addr_d    = pipe_addr_i;
            write_data_d = pipe_data_i;
        end else if (pop_s && !is_gpr_zero(head_s.addr)) begin
            rd_write_d   = 1'b1;
            rd_addr_d    = head_s.addr;
            write_data_d = head_s.data;
        end else begin
            rd_write_d = 1'b0;
        end
    end

    // Clear before set so a re-issue on the popping edge keeps the register pending.
    always_comb begin
        busy_d = busy_q;
        if (pop_s) begin
            busy_d[head_s.addr] = 1'b0;
        end else begin
            busy_d = busy_q;
        end
        if (lu_issue_i && !is_gpr_zero(lu_issue_addr_i)) begin
            busy_d[lu_issue_addr_i] = 1'b1;
        end else begin
            busy_d[0] = 1'b0;
        end
    end

    assign hazard_o = busy_q[chk1_addr_i] | busy_q[chk2_addr_i] | busy_q[chkd_addr_i];

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q       <= 32'd0;
            rd_write_q   <= 1'b0;
            rd_addr_q    <= GPR_ZERO_ADDR;
            write_data_q <= 32'd0;
        end else begin
            busy_q       <= busy_d;
            rd_write_q   <= rd_write_d;
            rd_addr_q    <= rd_addr_d;
            write_data_q <= write_data_d;
        end
    end

    assign rd_write_o   = rd_write_q;
    assign rd_addr_o    = rd_addr_q;
    assign write_data_o = write_data_q;

`ifdef GPR_WB_STARVE_EN
    localparam int unsigned STARVE_CNT_W = $clog2(STARVE_MAX + 1);

    logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                    pipe_hold_q, pipe_hold_d;

    // The hold cycle always pops, so the counter never runs past STARVE_MAX.
    always_comb begin
        if (pop_s) begin
            starve_cnt_d = {STARVE_CNT_W{1'b0}};
        end else if (!empty_s) begin
            starve_cnt_d = starve_cnt_q + STARVE_CNT_W'(1);
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
        pipe_hold_d = (starve_cnt_d == STARVE_CNT_W'(STARVE_MAX));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= {STARVE_CNT_W{1'b0}};
            pipe_hold_q  <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            pipe_hold_q  <= pipe_hold_d;
        end
    end

    assign pipe_hold_s = pipe_hold_q;
`else
    // STARVE_MAX only matters when the starvation hold is built in.
    localparam int unsigned unused_starve_max = STARVE_MAX;

    assign pipe_hold_s = 1'b0;
`endif

    assign pipe_hold_o = pipe_hold_s;

endmodule

// File: tb/tb_gpr_write_ctrl.sv
// Directed bench for gpr_write_ctrl: expected GPR writes are queued by the stimulus and checked by a monitor.
module tb_gpr_write_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_we_i = 1'b0;
    logic [4:0]  pipe_addr_i = 5'd0;
    logic [31:0] pipe_data_i = 32'd0;
    logic        lu_issue_i = 1'b0;
    logic [4:0]  lu_issue_addr_i = 5'd0;
    logic        lu_valid_i = 1'b0;
    logic [4:0]  lu_addr_i = 5'd0;
    logic [31:0] lu_data_i = 32'd0;
    logic        lu_ready_o;
    logic [4:0]  chk1_addr_i = 5'd0;
    logic [4:0]  chk2_addr_i = 5'd0;
    logic [4:0]  chkd_addr_i = 5'd0;
    logic        hazard_o;
    logic        pipe_hold_o;
    logic        rd_write_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] write_data_o;

    int total = 0;
    int bad   = 0;
    logic [36:0] exp_q [$];

    gpr_write_ctrl #(
        .LU_FIFO_DEPTH (2),
        .STARVE_MAX    (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pipe_we_i       (pipe_we_i),
        .pipe_addr_i     (pipe_addr_i),
        .pipe_data_i     (pipe_data_i),
        .lu_issue_i      (lu_issue_i),
        .lu_issue_addr_i (lu_issue_addr_i),
        .lu_valid_i      (lu_valid_i),
        .lu_addr_i       (lu_addr_i),
        .lu_data_i       (lu_data_i),
        .lu_ready_o      (lu_ready_o),
        .chk1_addr_i     (chk1_addr_i),
        .chk2_addr_i     (chk2_addr_i),
        .chkd_addr_i     (chkd_addr_i),
        .hazard_o        (hazard_o),
        .pipe_hold_o     (pipe_hold_o),
        .rd_write_o      (rd_write_o),
        .rd_addr_o       (rd_addr_o),
        .write_data_o    (write_data_o)
    );

    always #5 clk = ~clk;

    // Monitor: every presented GPR write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rd_write_o) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL write_unexpected: got r%0d=0x%08h, required no write", rd_addr_o, write_data_o);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({rd_addr_o, write_data_o} !== e) begin
                    bad++;
                    $display("FAIL write_order: got r%0d=0x%08h, required r%0d=0x%08h",
                             rd_addr_o, write_data_o, e[36:32], e[31:0]);
                end
            end
        end
    end

    // Protocol rules decode and the pipeline are expected to honour.
    always @(negedge clk) begin
        if (!rst) begin
            assert (!(lu_issue_i && lu_issue_addr_i != 5'd0 && dut.busy_q[lu_issue_addr_i] &&
                      !(dut.pop_s && dut.head_s.addr == lu_issue_addr_i)))
                else $error("issue to busy register r%0d", lu_issue_addr_i);
            assert (!(pipe_we_i && pipe_addr_i != 5'd0 && dut.busy_q[pipe_addr_i] &&
                      !(dut.pop_s && dut.head_s.addr == pipe_addr_i)))
                else $error("pipeline write to busy register r%0d", pipe_addr_i);
            assert (!(pipe_we_i && pipe_hold_o))
                else $error("pipeline write while held");
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic cyc(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                       input logic iss, input logic [4:0] ia,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
        pipe_we_i = pwe; pipe_addr_i = pa; pipe_data_i = pd;
        lu_issue_i = iss; lu_issue_addr_i = ia;
        lu_valid_i = lv; lu_addr_i = la; lu_data_i = ld;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic haz(input string name, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] ad, input logic req);
        chk1_addr_i = a1; chk2_addr_i = a2; chkd_addr_i = ad;
        #1;
        chk(name, {31'd0, hazard_o}, {31'd0, req});
    endtask

    task automatic expw(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    initial begin
        rst = 1'b1;
        idle();
        idle();
        chk("rst_rd_write", {31'd0, rd_write_o}, 32'd0);
        chk("rst_rd_addr", {27'd0, rd_addr_o}, 32'd0);
        chk("rst_write_data", write_data_o, 32'd0);
        chk("rst_pipe_hold", {31'd0, pipe_hold_o}, 32'd0);
        chk("rst_lu_ready", {31'd0, lu_ready_o}, 32'd1);
        haz("rst_hazard", 5'd1, 5'd2, 5'd3, 1'b0);
        rst = 1'b0;
        idle();

        // Pipeline write with empty FIFO: one-cycle latency.
        expw(5'd5, 32'h0000_1234);
        cyc(1'b1, 5'd5, 32'h0000_1234, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        chk("pipe_rd_write", {31'd0, rd_write_o}, 32'd1);
        chk("pipe_rd_addr", {27'd0, rd_addr_o}, 32'd5);
        chk("pipe_write_data", write_data_o, 32'h0000_1234);

        // Pipeline write to r0 is dropped.
        cyc(1'b1, 5'd0, 32'h0000_dead, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        chk("r0_pipe_dropped", {31'd0, rd_write_o}, 32'd0);

        // Issue r7, return it, hazard clears as the write appears.
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0);
        haz("haz_chk1_r7", 5'd7, 5'd0, 5'd0, 1'b1);
        haz("haz_chkd_r7", 5'd0, 5'd0, 5'd7, 1'b1);
        haz("haz_r0_only", 5'd0, 5'd0, 5'd0, 1'b0);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd7, 32'h0000_beef);
        haz("haz_r7_buffered", 5'd7, 5'd0, 5'd0, 1'b1);
        chk("ready_one_entry", {31'd0, lu_ready_o}, 32'd1);
        expw(5'd7, 32'h0000_beef);
        idle();
        chk("lu_rd_write", {31'd0, rd_write_o}, 32'd1);
        chk("lu_rd_addr", {27'd0, rd_addr_o}, 32'd7);
        haz("haz_r7_cleared", 5'd7, 5'd0, 5'd0, 1'b0);

        // Fill FIFO behind continuous pipeline writes; third result waits for a pop.
        expw(5'd1, 32'h11);
        cyc(1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 1'b1, 5'd10, 32'ha0);
        expw(5'd2, 32'h22);
        cyc(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 1'b1, 5'd11, 32'ha1);
        chk("full_not_ready", {31'd0, lu_ready_o}, 32'd0);
        expw(5'd3, 32'h33);
        cyc(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 1'b1, 5'd12, 32'ha2);
        chk("full_held", {31'd0, lu_ready_o}, 32'd0);
        expw(5'd10, 32'ha0);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd12, 32'ha2);
        chk("pop_frees_slot", {31'd0, lu_ready_o}, 32'd1);
        expw(5'd11, 32'ha1);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd12, 32'ha2);
        expw(5'd12, 32'ha2);
        idle();
        chk("drained_ready", {31'd0, lu_ready_o}, 32'd1);
        chk("drained_rd_addr", {27'd0, rd_addr_o}, 32'd12);

        // FIFO entry for r0 is popped without a write.
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd0, 32'h55);
        idle();
        chk("r0_lu_dropped", {31'd0, rd_write_o}, 32'd0);
        idle();

        // Starvation: pipeline writes every cycle while r20 waits.
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd20, 32'hc0);
        for (int i = 0; i < 4; i++) begin
            expw(5'(21 + i), 32'h100 + 32'(i));
            cyc(1'b1, 5'(21 + i), 32'h100 + 32'(i), 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
            if (i == 2) chk("hold_not_yet", {31'd0, pipe_hold_o}, 32'd0);
        end
`ifdef GPR_WB_STARVE_EN
        chk("hold_after_4", {31'd0, pipe_hold_o}, 32'd1);
`else
        chk("hold_never", {31'd0, pipe_hold_o}, 32'd0);
        chk("no_drain_rd_addr", {27'd0, rd_addr_o}, 32'd24);
`endif
        expw(5'd20, 32'hc0);
        idle();
        chk("starved_rd_addr", {27'd0, rd_addr_o}, 32'd20);
        chk("hold_one_cycle", {31'd0, pipe_hold_o}, 32'd0);

        // Re-issue r9 on the edge that pops r9: set wins.
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd9, 32'h99);
        expw(5'd9, 32'h99);
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0);
        chk("reissue_rd_addr", {27'd0, rd_addr_o}, 32'd9);
        haz("reissue_busy_r9", 5'd9, 5'd0, 5'd0, 1'b1);

        // Reset with busy r3/r4 and two queued results flushes everything.
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 5'd0, 32'd0);
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b0, 5'd0, 32'd0);
        expw(5'd1, 32'h1);
        cyc(1'b1, 5'd1, 32'h1, 1'b0, 5'd0, 1'b1, 5'd3, 32'h3);
        expw(5'd2, 32'h2);
        cyc(1'b1, 5'd2, 32'h2, 1'b0, 5'd0, 1'b1, 5'd4, 32'h4);
        chk("pre_rst_full", {31'd0, lu_ready_o}, 32'd0);
        haz("pre_rst_busy", 5'd3, 5'd4, 5'd0, 1'b1);
        rst = 1'b1;
        idle();
        chk("mid_rst_rd_write", {31'd0, rd_write_o}, 32'd0);
        chk("mid_rst_rd_addr", {27'd0, rd_addr_o}, 32'd0);
        chk("mid_rst_write_data", write_data_o, 32'd0);
        chk("mid_rst_pipe_hold", {31'd0, pipe_hold_o}, 32'd0);
        chk("mid_rst_lu_ready", {31'd0, lu_ready_o}, 32'd1);
        haz("mid_rst_hazard", 5'd3, 5'd4, 5'd9, 1'b0);
        rst = 1'b0;
        idle();
        idle();
        idle();
        chk("post_rst_no_write", {31'd0, rd_write_o}, 32'd0);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
